// File: rtl/card_pkg.sv
// Shared constants and types for the card draw controller.
//   CARD_W x CARD_H card image held in a 2**ADDR_W deep, COLOR_W wide memory.
//   XY_W-bit screen coordinates; TRANSPARENT marks "no card pixel".
//   card_ctrl_state_t encodes the blanking-only write arbiter.
package card_pkg;

  localparam int unsigned CARD_W  = 16;
  localparam int unsigned CARD_H  = 32;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned XY_W    = 8;

  // Number of low dx/dy bits that index into the card.
  localparam int unsigned X_BITS = $clog2(CARD_W);
  localparam int unsigned Y_BITS = $clog2(CARD_H);

  localparam logic [COLOR_W-1:0] TRANSPARENT = 3'b000;

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_WRITE  = 2'd1,
    ST_ACTIVE = 2'd2
  } card_ctrl_state_t;

endpackage

// File: rtl/card_addr_gen.sv
// Read-side hit test and stage-1 address register.
//   i_clock      rising-edge clock
//   i_reset_n    synchronous active-low reset
//   i_pixel_x/y  current pixel coordinate
//   i_card_x/y   latched card origin
//   i_card_en    latched card enable
//   i_video_on   active display area
//   o_raddr      registered card memory read address (holds on a miss)
//   o_re         registered read enable (follows video_on)
//   o_hit1       registered hit flag aligned with o_raddr
module card_addr_gen
  import card_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [XY_W-1:0]   i_pixel_x,
  input  logic [XY_W-1:0]   i_pixel_y,
  input  logic [XY_W-1:0]   i_card_x,
  input  logic [XY_W-1:0]   i_card_y,
  input  logic              i_card_en,
  input  logic              i_video_on,
  output logic [ADDR_W-1:0] o_raddr,
  output logic              o_re,
  output logic              o_hit1
);

  logic [XY_W:0]     w_dx;
  logic [XY_W:0]     w_dy;
  logic              w_in_x;
  logic              w_in_y;
  logic              w_hit;
  logic [ADDR_W-1:0] w_addr;

  logic [ADDR_W-1:0] r_raddr;
  logic              r_re;
  logic              r_hit1;

  // One extra bit keeps the borrow: a pixel left of / above the origin
  // sets the MSB and fails the range test, so cards clip instead of wrap.
  assign w_dx = {1'b0, i_pixel_x} - {1'b0, i_card_x};
  assign w_dy = {1'b0, i_pixel_y} - {1'b0, i_card_y};

  // Upper bits all zero <=> no borrow and offset below the card size.
  assign w_in_x = (w_dx[XY_W:X_BITS] == '0);
  assign w_in_y = (w_dy[XY_W:Y_BITS] == '0);

  assign w_hit  = w_in_x && w_in_y && i_video_on && i_card_en;
  assign w_addr = {w_dy[Y_BITS-1:0], w_dx[X_BITS-1:0]};

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_raddr <= '0;
      r_re    <= 1'b0;
      r_hit1  <= 1'b0;
    end else begin
      r_re   <= i_video_on;
      r_hit1 <= w_hit;
      if (w_hit) begin
        r_raddr <= w_addr;
      end
    end
  end

  assign o_raddr = r_raddr;
  assign o_re    = r_re;
  assign o_hit1  = r_hit1;

endmodule

// File: rtl/card_draw_ctrl.sv
// Card image memory sequencer.
//   Read side : maps VGA pixel coordinates to card memory addresses for a
//               card placed at a per-frame origin; 3-cycle pixel latency.
//   Write side: grants host writes only while video is blanked.
// Ports:
//   clock, reset_n                 clock, synchronous active-low reset
//   pixel_x, pixel_y, video_on     VGA timing inputs
//   frame_start                    origin/enable latch strobe
//   card_x, card_y, card_en        card placement (sampled on frame_start)
//   wr_req, wr_addr, wr_data       host write request (held until wr_ack)
//   wr_ack                         1-cycle write-performed pulse
//   mem_we/mem_waddr/mem_wdata     memory write port
//   mem_re/mem_raddr/mem_rdata     memory read port (1-cycle latency)
//   pix_hit, pix_color             card pixel to the colour mux
module card_draw_ctrl
  import card_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [XY_W-1:0]    pixel_x,
  input  logic [XY_W-1:0]    pixel_y,
  input  logic               video_on,
  input  logic               frame_start,
  input  logic [XY_W-1:0]    card_x,
  input  logic [XY_W-1:0]    card_y,
  input  logic               card_en,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ack,
  output logic               mem_we,
  output logic               mem_re,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [COLOR_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic               pix_hit,
  output logic [COLOR_W-1:0] pix_color
);

  // ---------------- origin latch ----------------
  logic [XY_W-1:0] r_card_x;
  logic [XY_W-1:0] r_card_y;
  logic            r_card_en;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_card_x  <= '0;
      r_card_y  <= '0;
      r_card_en <= 1'b0;
    end else if (frame_start) begin
      r_card_x  <= card_x;
      r_card_y  <= card_y;
      r_card_en <= card_en;
    end
  end

  // ---------------- read pipeline ----------------
  logic               w_hit1;
  logic               r_hit2;
  logic               r_pix_hit;
  logic [COLOR_W-1:0] r_pix_color;

  card_addr_gen u_addr_gen (
    .i_clock    (clock),
    .i_reset_n  (reset_n),
    .i_pixel_x  (pixel_x),
    .i_pixel_y  (pixel_y),
    .i_card_x   (r_card_x),
    .i_card_y   (r_card_y),
    .i_card_en  (r_card_en),
    .i_video_on (video_on),
    .o_raddr    (mem_raddr),
    .o_re       (mem_re),
    .o_hit1     (w_hit1)
  );

  // r_hit2 rides alongside the memory access cycle so it lines up with
  // mem_rdata at the stage-2 register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_hit2      <= 1'b0;
      r_pix_hit   <= 1'b0;
      r_pix_color <= '0;
    end else begin
      r_hit2      <= w_hit1;
      r_pix_hit   <= r_hit2 && (mem_rdata != TRANSPARENT);
      r_pix_color <= r_hit2 ? mem_rdata : '0;
    end
  end

  assign pix_hit   = r_pix_hit;
  assign pix_color = r_pix_color;

  // ---------------- write arbiter ----------------
  card_ctrl_state_t   r_state;
  card_ctrl_state_t   w_next_state;
  logic               w_grant;
  logic               w_write;
  logic [ADDR_W-1:0]  r_waddr;
  logic [COLOR_W-1:0] r_wdata;

  assign w_grant = (r_state == ST_BLANK) && wr_req && !video_on;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_BLANK;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_BLANK: begin
        if (wr_req && !video_on) begin
          w_next_state = ST_WRITE;
        end else if (video_on) begin
          w_next_state = ST_ACTIVE;
        end
      end
      ST_WRITE:  w_next_state = video_on ? ST_ACTIVE : ST_BLANK;
      ST_ACTIVE: begin
        if (!video_on) begin
          w_next_state = ST_BLANK;
        end
      end
      default:   w_next_state = ST_BLANK;
    endcase
  end

  // Gating with reset_n aborts a write whose cycle coincides with reset,
  // so the memory never sees WE at that edge.
  always_comb begin
    w_write = 1'b0;
    if ((r_state == ST_WRITE) && reset_n) begin
      w_write = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_waddr <= wr_addr;
      r_wdata <= wr_data;
    end
  end

  assign wr_ack    = w_write;
  assign mem_we    = w_write;
  assign mem_waddr = r_waddr;
  assign mem_wdata = r_wdata;

endmodule
